// File: rtl/gb_alu_queue.sv
// Game Boy ALU/INC opcode queue + executor; optional retire counter under GB_RETIRE_CNT_EN.
// Push at edge t executes at t+1 and is seen on probe after t+2. ready = !full; stall holds execution only.
module gb_alu_queue #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [7:0]        instruction,
  input  logic              stall,
  input  logic [2:0]        probe_sel,
  output logic [DATA_W-1:0] probe,
  output logic [3:0]        flags,
  output logic              err
`ifdef GB_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic [3:0]        flags_q, flags_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] probe_q;

  logic              empty, full, push, pop;
  logic [7:0]        op;
  logic              is_alu, is_inc, illegal;
  logic [DATA_W-1:0] acc, src, dst, res, inc_res;
  logic [DATA_W:0]   wide, cin_w;
  logic [4:0]        half, cin5;
  logic              cin;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign ready = !full;
  assign push  = valid && !full;
  assign pop   = !empty && !stall;

  assign op      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign is_alu  = (op[7:6] == 2'b10);
  assign is_inc  = (op[7:6] == 2'b00) && (op[2:0] == 3'b100);
  // Index 6 is the (HL) memory operand, which this core does not model.
  assign illegal = (is_alu && op[2:0] == 3'd6) || (is_inc && op[5:3] == 3'd6);

  assign acc     = regs_q[7];
  assign src     = regs_q[op[2:0]];
  assign dst     = regs_q[op[5:3]];
  assign inc_res = dst + {{(DATA_W-1){1'b0}}, 1'b1};
  // Carry-in only for ADC/SBC (alu op 001/011).
  assign cin     = !op[5] && op[3] && flags_q[0];
  assign cin_w   = {{DATA_W{1'b0}}, cin};
  assign cin5    = {4'b0000, cin};

  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    err_d   = err_q;
    wide    = '0;
    half    = '0;
    res     = '0;
    if (pop) begin
      if (illegal) begin
        err_d = 1'b1;
      end else if (is_alu) begin
        case (op[5:3])
          3'd0, 3'd1: begin
            wide    = {1'b0, acc} + {1'b0, src} + cin_w;
            half    = {1'b0, acc[3:0]} + {1'b0, src[3:0]} + cin5;
            res     = wide[DATA_W-1:0];
            flags_d = {res == '0, 1'b0, half[4], wide[DATA_W]};
            regs_d[7] = res;
          end
          3'd2, 3'd3, 3'd7: begin
            wide    = {1'b0, acc} - {1'b0, src} - cin_w;
            half    = {1'b0, acc[3:0]} - {1'b0, src[3:0]} - cin5;
            res     = wide[DATA_W-1:0];
            flags_d = {res == '0, 1'b1, half[4], wide[DATA_W]};
            if (op[5:3] != 3'd7) regs_d[7] = res;
          end
          3'd4: begin
            res     = acc & src;
            flags_d = {res == '0, 1'b0, 1'b1, 1'b0};
            regs_d[7] = res;
          end
          3'd5: begin
            res     = acc ^ src;
            flags_d = {res == '0, 3'b000};
            regs_d[7] = res;
          end
          default: begin
            res     = acc | src;
            flags_d = {res == '0, 3'b000};
            regs_d[7] = res;
          end
        endcase
      end else if (is_inc) begin
        regs_d[op[5:3]] = inc_res;
        flags_d = {inc_res == '0, 1'b0, dst[3:0] == 4'hF, flags_q[0]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= instruction;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      probe_q  <= '0;
      regs_q[0] <= DATA_W'(1);
      regs_q[1] <= DATA_W'(2);
      regs_q[2] <= DATA_W'(3);
      regs_q[3] <= DATA_W'(4);
      regs_q[4] <= DATA_W'(5);
      regs_q[5] <= DATA_W'(6);
      regs_q[6] <= '0;
      regs_q[7] <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      regs_q  <= regs_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      probe_q <= (probe_sel == 3'd6) ? {{(DATA_W-4){1'b0}}, flags_q} : regs_q[probe_sel];
    end
  end

  assign probe = probe_q;
  assign flags = flags_q;
  assign err   = err_q;

`ifdef GB_RETIRE_CNT_EN
  logic [15:0] retired_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (pop && !illegal && retired_q != 16'hFFFF) begin
      retired_q <= retired_q + 16'd1;
    end
  end
  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_gb_alu_queue.sv
// Directed-vector bench for gb_alu_queue with hand-computed expectations.
module tb_gb_alu_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid;
  logic       ready;
  logic [7:0] instruction;
  logic       stall;
  logic [2:0] probe_sel;
  logic [7:0] probe;
  logic [3:0] flags;
  logic       err;
`ifdef GB_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int n_vec = 0;
  int n_bad = 0;

  gb_alu_queue #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready),
    .instruction(instruction), .stall(stall), .probe_sel(probe_sel),
    .probe(probe), .flags(flags), .err(err)
`ifdef GB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0; stall = 1'b0; instruction = 8'h00; reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] o);
    valid = 1'b1; instruction = o;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_regs [8];
    exp_regs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    probe_sel = 3'd0;
    do_reset();
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_vec++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags got %h want 0", flags); end
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL reset_probe got %h want 00", probe); end
    for (int i = 0; i < 8; i++) begin
      probe_sel = 3'(i);
      tick();
      n_vec++;
      if (probe !== exp_regs[i]) begin
        n_bad++; $display("FAIL reset_reg%0d got %h want %h", i, probe, exp_regs[i]);
      end
    end
  endtask

  task automatic test_adc();
    do_reset();
    probe_sel = 3'd7;
    push(8'h8C);
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL adc_probe_early got %h want 00", probe); end
    tick();
    n_vec++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL adc_flags got %b want 0000", flags); end
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL adc_probe_t1 got %h want 00", probe); end
    tick();
    n_vec++; if (probe !== 8'h05) begin n_bad++; $display("FAIL adc_probe_t2 got %h want 05", probe); end
  endtask

  task automatic test_sub_a();
    do_reset();
    probe_sel = 3'd7;
    push(8'h97);
    tick();
    n_vec++; if (flags !== 4'b1100) begin n_bad++; $display("FAIL suba_flags got %b want 1100", flags); end
    tick();
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL suba_a got %h want 00", probe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [3];
    logic [3:0] exp_f [3];
    logic [7:0] exp_a [3];
    ops   = '{8'h90, 8'h80, 8'h89};
    exp_f = '{4'b0111, 4'b1011, 4'b0000};
    exp_a = '{8'hFF, 8'h00, 8'h03};
    do_reset();
    probe_sel = 3'd7;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) instruction = ops[i];
      else valid = 1'b0;
      tick();
      if (i >= 1 && i <= 3) begin
        n_vec++;
        if (flags !== exp_f[i-1]) begin
          n_bad++; $display("FAIL b2b_flags%0d got %b want %b", i-1, flags, exp_f[i-1]);
        end
      end
      if (i >= 2) begin
        n_vec++;
        if (probe !== exp_a[i-2]) begin
          n_bad++; $display("FAIL b2b_a%0d got %h want %h", i-2, probe, exp_a[i-2]);
        end
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_logic();
    logic [7:0] ops [6];
    logic [3:0] exp_f [6];
    ops   = '{8'h3C, 8'hA0, 8'hA9, 8'hB2, 8'hB8, 8'h76};
    exp_f = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    do_reset();
    probe_sel = 3'd7;
    for (int i = 0; i < 6; i++) begin
      push(ops[i]);
      tick();
      n_vec++;
      if (flags !== exp_f[i]) begin
        n_bad++; $display("FAIL logic_flags op%h got %b want %b", ops[i], flags, exp_f[i]);
      end
    end
    tick();
    n_vec++; if (probe !== 8'h03) begin n_bad++; $display("FAIL logic_a got %h want 03", probe); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL logic_nop_err got %b want 0", err); end
  endtask

  task automatic test_stall();
    int acc_cnt;
    do_reset();
    acc_cnt = 0;
    stall = 1'b1; valid = 1'b1; instruction = 8'h04;
    for (int i = 0; i < 5; i++) begin
      if (ready) acc_cnt++;
      tick();
    end
    n_vec++; if (acc_cnt !== 4) begin n_bad++; $display("FAIL stall_accepts got %0d want 4", acc_cnt); end
    n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL stall_full_ready got %b want 0", ready); end
    stall = 1'b0;
    tick();
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready got %b want 1", ready); end
    tick();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    probe_sel = 3'd0;
    tick();
    n_vec++; if (probe !== 8'h06) begin n_bad++; $display("FAIL stall_b got %h want 06", probe); end
    n_vec++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL stall_flags got %b want 0000", flags); end
  endtask

  task automatic test_illegal();
    do_reset();
    probe_sel = 3'd7;
    valid = 1'b1; instruction = 8'h86;
    tick();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill_err_early got %b want 0", err); end
    instruction = 8'h34;
    tick();
    valid = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err got %b want 1", err); end
    tick();
    tick();
    n_vec++; if (flags !== 4'h0) begin n_bad++; $display("FAIL ill_flags got %b want 0000", flags); end
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL ill_a got %h want 00", probe); end
    push(8'h80);
    tick();
    tick();
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky got %b want 1", err); end
    n_vec++; if (probe !== 8'h01) begin n_bad++; $display("FAIL ill_after_a got %h want 01", probe); end
    do_reset();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill_reset_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(8'h04);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h3C);
    stall = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", ready); end
    n_vec++; if (flags !== 4'h0) begin n_bad++; $display("FAIL mid_flags got %b want 0000", flags); end
    probe_sel = 3'd7;
    tick();
    n_vec++; if (probe !== 8'h00) begin n_bad++; $display("FAIL mid_a got %h want 00", probe); end
    probe_sel = 3'd0;
    tick();
    n_vec++; if (probe !== 8'h01) begin n_bad++; $display("FAIL mid_b got %h want 01", probe); end
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; stall = 1'b0; instruction = 8'h00; probe_sel = 3'd0;
    test_reset();
    test_adc();
    test_sub_a();
    test_back_to_back();
    test_logic();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
